switch_debouncer: RTL

Conditions the raw Arty Z7 slide switches before they reach the switch-to-LED decoder. Each raw switch bit is synchronised into the clock domain and then debounced: a change is accepted only after the new level has held for CNT_MAX consecutive cycles. The debounced bus drives the decoder's 2-bit sw input directly. A one-cycle change strobe is produced for downstream vending-machine logic.

---
 rtl/sw_debounce_pkg.sv | 14 +
 rtl/debounce_bit.sv | 59 +++++
 rtl/switch_debouncer.sv | 44 ++++
 3 files changed

// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared timing constants and state type for the switch debouncer
package sw_debounce_pkg;

    localparam int CLK_FREQ_HZ     = 125000000;
    localparam int DEBOUNCE_MS     = 10;
    localparam int DEFAULT_CNT_MAX = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int SIM_CNT_MAX     = 4;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - single-bit synchroniser, stability counter and clean flop
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int CNT_MAX     = DEFAULT_CNT_MAX,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic clean,
    output logic changed
);

    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   clean_d;
    logic                   changed_d;
    db_state_e              state;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean   <= 1'b0;
            changed <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q   <= cnt_d;
            clean   <= clean_d;
            changed <= changed_d;
        end
    end

    // The state is implied by the synchronised level disagreeing with the
    // accepted one; returning to agreement before the window ends rejects it.
    always_comb begin
        state     = (sync_bit != clean) ? DB_COUNTING : DB_STABLE;
        cnt_d     = '0;
        clean_d   = clean;
        changed_d = 1'b0;
        if (state == DB_COUNTING) begin
            if (cnt_q == CNT_LAST) begin
                clean_d   = sync_bit;
                changed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-bit switch debouncer with change strobe; SW_DEBOUNCE_EDGE_EN adds rise/fall strobes
module switch_debouncer
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int CNT_MAX     = DEFAULT_CNT_MAX,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
`ifdef SW_DEBOUNCE_EDGE_EN
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
`endif
    output logic             sw_changed
);

    logic [WIDTH-1:0] bit_changed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CNT_MAX    (CNT_MAX),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .raw    (sw_raw[i]),
            .clean  (sw_clean[i]),
            .changed(bit_changed[i])
        );
    end

    // Per-bit flags are flops, so the merged strobe stays glitch-free and
    // simultaneous acceptances collapse into one pulse.
    assign sw_changed = |bit_changed;

`ifdef SW_DEBOUNCE_EDGE_EN
    assign sw_rise = bit_changed & sw_clean;
    assign sw_fall = bit_changed & ~sw_clean;
`endif

endmodule
